// File: rtl/dnoc_l2_dmem_wr_arb.sv
// Round-robin write-port arbiter: core write interface vs. NoC-inbound writes onto one L2 dmem SRAM port.
// Returns a fixed-latency response pulse to the owner of each write and keeps saturating per-requester counts.
module dnoc_l2_dmem_wr_arb #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 256,
  parameter int RESP_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_wr_req,
  output logic              core_wr_gnt,
  input  logic [ADDR_W-1:0] core_wr_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_wr_resp,
  input  logic              noc_wr_req,
  output logic              noc_wr_gnt,
  input  logic [ADDR_W-1:0] noc_wr_addr,
  input  logic [DATA_W-1:0] noc_wr_data,
  output logic              noc_wr_resp,
  input  logic              sram_ready,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  core_wr_cnt,
  output logic [CNT_W-1:0]  noc_wr_cnt,
  output logic              busy
);

  logic                r_prio_noc;
  logic [RESP_LAT-1:0] r_pipe_vld;
  logic [RESP_LAT-1:0] r_pipe_own;
  logic [CNT_W-1:0]    r_core_cnt;
  logic [CNT_W-1:0]    r_noc_cnt;
  logic                w_core_gnt;
  logic                w_noc_gnt;

  // Grants are held off while reset is asserted so all gnt outputs read 0 during reset.
  always_comb begin
    w_core_gnt = 1'b0;
    w_noc_gnt  = 1'b0;
    if (sram_ready && !rst) begin
      if (core_wr_req && noc_wr_req) begin
        w_noc_gnt  = r_prio_noc;
        w_core_gnt = ~r_prio_noc;
      end else begin
        w_core_gnt = core_wr_req;
        w_noc_gnt  = noc_wr_req;
      end
    end
  end

  assign core_wr_gnt = w_core_gnt;
  assign noc_wr_gnt  = w_noc_gnt;
  assign sram_we     = w_core_gnt | w_noc_gnt;
  assign sram_addr   = w_core_gnt ? core_wr_addr : (w_noc_gnt ? noc_wr_addr : '0);
  assign sram_wdata  = w_core_gnt ? core_wr_data : (w_noc_gnt ? noc_wr_data : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio_noc <= 1'b0;
    end else if (w_core_gnt) begin
      r_prio_noc <= 1'b1;
    end else if (w_noc_gnt) begin
      r_prio_noc <= 1'b0;
    end
  end

  // Stage 0 captures this cycle's grant; the last stage is visible RESP_LAT cycles after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      r_pipe_own <= '0;
    end else begin
      for (int i = RESP_LAT - 1; i > 0; i--) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_own[i] <= r_pipe_own[i-1];
      end
      r_pipe_vld[0] <= w_core_gnt | w_noc_gnt;
      r_pipe_own[0] <= w_noc_gnt;
    end
  end

  assign core_wr_resp = r_pipe_vld[RESP_LAT-1] & ~r_pipe_own[RESP_LAT-1];
  assign noc_wr_resp  = r_pipe_vld[RESP_LAT-1] &  r_pipe_own[RESP_LAT-1];
  assign busy         = |r_pipe_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_core_cnt <= '0;
      r_noc_cnt  <= '0;
    end else if (cnt_clr) begin
      r_core_cnt <= '0;
      r_noc_cnt  <= '0;
    end else begin
      if (w_core_gnt && (r_core_cnt != {CNT_W{1'b1}})) begin
        r_core_cnt <= r_core_cnt + 1'b1;
      end
      if (w_noc_gnt && (r_noc_cnt != {CNT_W{1'b1}})) begin
        r_noc_cnt <= r_noc_cnt + 1'b1;
      end
    end
  end

  assign core_wr_cnt = r_core_cnt;
  assign noc_wr_cnt  = r_noc_cnt;

endmodule

// File: tb/tb_dnoc_l2_dmem_wr_arb.sv
// Bench for dnoc_l2_dmem_wr_arb: directed scenarios plus random traffic, all checked every cycle
// against a transaction-level model (next-owner bit, scheduled-response list, saturating counts).
module tb_dnoc_l2_dmem_wr_arb;
  localparam int AW  = 13;
  localparam int DW  = 64;
  localparam int LAT = 3;
  localparam int CW  = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          core_wr_req, noc_wr_req;
  logic          core_wr_gnt, noc_wr_gnt;
  logic [AW-1:0] core_wr_addr, noc_wr_addr;
  logic [DW-1:0] core_wr_data, noc_wr_data;
  logic          core_wr_resp, noc_wr_resp;
  logic          sram_ready, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          cnt_clr;
  logic [CW-1:0] core_wr_cnt, noc_wr_cnt;
  logic          busy;

  dnoc_l2_dmem_wr_arb #(
    .ADDR_W(AW), .DATA_W(DW), .RESP_LAT(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .core_wr_req(core_wr_req), .core_wr_gnt(core_wr_gnt),
    .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data), .core_wr_resp(core_wr_resp),
    .noc_wr_req(noc_wr_req), .noc_wr_gnt(noc_wr_gnt),
    .noc_wr_addr(noc_wr_addr), .noc_wr_data(noc_wr_data), .noc_wr_resp(noc_wr_resp),
    .sram_ready(sram_ready), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .cnt_clr(cnt_clr), .core_wr_cnt(core_wr_cnt), .noc_wr_cnt(noc_wr_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_core_resp = 0;

  // Model state: who wins a tie next, when each response is due and to whom, and write counts.
  bit m_noc_next;
  int m_core_cnt, m_noc_cnt;
  int q_due[$];
  bit q_own[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_noc_next = 1'b0;
    m_core_cnt = 0;
    m_noc_cnt  = 0;
    q_due.delete();
    q_own.delete();
  endtask

  task automatic run_cycle();
    bit e_core, e_noc, e_rc, e_rn, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    @(negedge clk);
    if (rst) model_reset();
    e_core = 1'b0;
    e_noc  = 1'b0;
    if (!rst && sram_ready) begin
      if (core_wr_req && noc_wr_req) begin
        e_noc  = m_noc_next;
        e_core = !m_noc_next;
      end else begin
        e_core = core_wr_req;
        e_noc  = noc_wr_req;
      end
    end
    e_addr = e_core ? core_wr_addr : (e_noc ? noc_wr_addr : '0);
    e_data = e_core ? core_wr_data : (e_noc ? noc_wr_data : '0);
    e_rc = 1'b0;
    e_rn = 1'b0;
    e_busy = 1'b0;
    foreach (q_due[k]) begin
      if (q_due[k] == cyc) begin
        if (q_own[k]) e_rn = 1'b1;
        else          e_rc = 1'b1;
      end
      if (q_due[k] >= cyc && q_due[k] - LAT < cyc) e_busy = 1'b1;
    end
    check_val("gnt", {core_wr_gnt, noc_wr_gnt}, {e_core, e_noc});
    check_val("sram_we", sram_we, e_core | e_noc);
    check_val("sram_addr", sram_addr, e_addr);
    check_val("sram_wdata", sram_wdata, e_data);
    check_val("resp", {core_wr_resp, noc_wr_resp}, {e_rc, e_rn});
    check_val("busy", busy, e_busy);
    check_val("core_cnt", core_wr_cnt, m_core_cnt);
    check_val("noc_cnt", noc_wr_cnt, m_noc_cnt);
    if (core_wr_resp) n_core_resp++;
    if (e_core || e_noc)
      $display("cycle %0d grant %s addr=%0h", cyc, e_core ? "core" : "noc", e_addr);
    @(posedge clk);
    if (!rst) begin
      if (cnt_clr) begin
        m_core_cnt = 0;
        m_noc_cnt  = 0;
      end else begin
        if (e_core && m_core_cnt < CMAX) m_core_cnt++;
        if (e_noc  && m_noc_cnt  < CMAX) m_noc_cnt++;
      end
      if (e_core || e_noc) begin
        m_noc_next = e_core;
        q_due.push_back(cyc + LAT);
        q_own.push_back(e_noc);
      end
      while (q_due.size() > 0 && q_due[0] <= cyc) begin
        void'(q_due.pop_front());
        void'(q_own.pop_front());
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input bit cr, input bit nr, input bit rdy, input bit clr, input bit rs);
    core_wr_req  = cr;
    noc_wr_req   = nr;
    sram_ready   = rdy;
    cnt_clr      = clr;
    rst          = rs;
    core_wr_addr = AW'($urandom);
    noc_wr_addr  = AW'($urandom);
    core_wr_data = {$urandom, $urandom};
    noc_wr_data  = {$urandom, $urandom};
    run_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1, 0, 0);
  endtask

  initial begin
    model_reset();
    core_wr_req = 0; noc_wr_req = 0; sram_ready = 1; cnt_clr = 0; rst = 1;
    core_wr_addr = '0; noc_wr_addr = '0; core_wr_data = '0; noc_wr_data = '0;
    #1;
    // Reset state with both requesting: nothing may be granted.
    drive(1, 1, 1, 0, 1);
    drive(0, 0, 1, 0, 1);
    idle(4);

    // Single core write.
    drive(1, 0, 1, 0, 0);
    idle(LAT + 2);

    // Contention from a fresh reset: core first, then alternate.
    drive(0, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) drive(1, 1, 1, 0, 0);
    idle(LAT + 2);

    // SRAM not ready stalls both; priority is kept.
    drive(0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    idle(LAT + 2);

    // Burst of 8 core writes: 8 consecutive responses.
    n_core_resp = 0;
    for (int i = 0; i < 8; i++) drive(1, 0, 1, 0, 0);
    idle(LAT + 2);
    check_val("burst_resp_count", n_core_resp, 8);

    // Reset while writes are in flight: no responses afterwards.
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0);
    n_core_resp = 0;
    drive(0, 0, 1, 0, 1);
    idle(LAT + 2);
    check_val("post_reset_resp_count", n_core_resp, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    idle(LAT + 1);

    // Counter saturation, then clear coinciding with a grant.
    for (int i = 0; i < CMAX + 3; i++) drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 1, 0);
    drive(0, 1, 1, 0, 0);
    idle(LAT + 1);

    // Random traffic, including rare resets and counter clears.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
    idle(LAT + 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
